mux_serializer: RTL and testbench

- Parallel-to-serial stage directly upstream of the 8-to-1 bit multiplexer.
- Accepts a WIDTH-bit word over a valid/ready handshake and holds it.
- Steps a select counter through every bit position. Each bit is presented on a valid/ready serial output.
- Exports the live select value so an external mux_8to1 can be driven in lock-step.

---
 rtl/mux_serializer.sv | 85 ++++++++
 tb/tb_mux_serializer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_serializer.sv
// Parallel-to-serial stage feeding an external 8-to-1 mux: holds one word and walks
// a select index across it, presenting each bit on a valid/ready serial port.
module mux_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SEL_W     = 3,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic [SEL_W-1:0] sel,
  output logic             last,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] SEL_FIRST = MSB_FIRST ? SEL_W'(WIDTH - 1) : '0;
  localparam logic [SEL_W-1:0] SEL_LAST  = MSB_FIRST ? '0 : SEL_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             accept;

  // Serial-side outputs decode registered state only; load_valid never reaches them.
  assign busy       = (state_q == SHIFT);
  assign ser_valid  = busy;
  assign last       = busy && (sel_q == SEL_LAST);
  assign ser_out    = busy && word_q[sel_q];
  assign sel        = sel_q;
  assign load_ready = !rst && (!busy || (last && ser_ready));
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          word_d  = load_data;
          sel_d   = SEL_FIRST;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          if (!last) begin
            sel_d = MSB_FIRST ? sel_q - SEL_W'(1) : sel_q + SEL_W'(1);
          end else if (accept) begin
            // Zero-bubble reload: next word starts on the cycle after the last bit.
            word_d = load_data;
            sel_d  = SEL_FIRST;
          end else begin
            sel_d   = SEL_FIRST;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      sel_q   <= SEL_FIRST;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: tb/tb_mux_serializer.sv
// Directed bench for mux_serializer: LSB-first instance for all scenarios plus an
// MSB-first instance fed the same stimulus for the ordering check.
module tb_mux_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] load_data;
  logic       load_valid;
  logic       ser_ready;

  logic       load_ready, ser_out, ser_valid, last, busy;
  logic [2:0] sel;
  logic       m_load_ready, m_ser_out, m_ser_valid, m_last, m_busy;
  logic [2:0] m_sel;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  mux_serializer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .ser_ready(ser_ready), .sel(sel), .last(last), .busy(busy)
  );

  mux_serializer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(m_load_ready), .ser_out(m_ser_out), .ser_valid(m_ser_valid),
    .ser_ready(ser_ready), .sel(m_sel), .last(m_last), .busy(m_busy)
  );

  // Present a word while idle; it is taken on the next rising edge.
  task automatic do_load(input logic [7:0] w);
    @(negedge clk);
    load_data  = w;
    load_valid = 1'b1;
    ser_ready  = 1'b1;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_valid = 1'b0; load_data = 8'h00; ser_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready got=%b exp=0", load_ready); end
    checks++;
    if ({ser_valid, ser_out, last, busy, sel} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs got v=%b o=%b l=%b b=%b sel=%0d exp all 0",
                         ser_valid, ser_out, last, busy, sel);
    end
    checks++;
    if (m_sel !== 3'd7) begin errors++; $display("FAIL reset_msb_sel got=%0d exp=7", m_sel); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b1) begin errors++; $display("FAIL idle_load_ready got=%b exp=1", load_ready); end
  endtask

  task automatic test_single();
    logic [7:0] w;
    logic [7:0] exp_bits;
    w = 8'hA5;
    do_load(w);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_bits = 8'b1010_0101; // bit i of A5, LSB first: 1,0,1,0,0,1,0,1
      checks++;
      if (ser_valid !== 1'b1 || sel !== 3'(i) || ser_out !== exp_bits[i] || last !== (i == 7)) begin
        errors++; $display("FAIL lsb_bit%0d got v=%b sel=%0d o=%b l=%b exp v=1 sel=%0d o=%b l=%b",
                           i, ser_valid, sel, ser_out, last, i, exp_bits[i], (i == 7));
      end
      checks++;
      if (m_ser_valid !== 1'b1 || m_sel !== 3'(7 - i) || m_ser_out !== exp_bits[7 - i] || m_last !== (i == 7)) begin
        errors++; $display("FAIL msb_bit%0d got v=%b sel=%0d o=%b l=%b exp v=1 sel=%0d o=%b l=%b",
                           i, m_ser_valid, m_sel, m_ser_out, m_last, 7 - i, exp_bits[7 - i], (i == 7));
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ser_valid !== 1'b0 || sel !== 3'd0) begin
      errors++; $display("FAIL single_done got b=%b v=%b sel=%0d exp b=0 v=0 sel=0", busy, ser_valid, sel);
    end
    checks++;
    if (m_busy !== 1'b0 || m_sel !== 3'd7) begin
      errors++; $display("FAIL msb_done got b=%b sel=%0d exp b=0 sel=7", m_busy, m_sel);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] w;
    int idx;
    int stall;
    w = 8'h3C;
    idx = 0;
    stall = 0;
    do_load(w);
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      checks++;
      if (ser_valid !== 1'b1 || sel !== 3'(idx) || ser_out !== w[idx]) begin
        errors++; $display("FAIL bp_cycle%0d got v=%b sel=%0d o=%b exp v=1 sel=%0d o=%b",
                           c, ser_valid, sel, ser_out, idx, w[idx]);
      end
      if (idx == 2 && stall < 5) begin
        ser_ready = 1'b0;
        stall++;
      end else begin
        ser_ready = 1'b1;
      end
      if (ser_ready) idx++;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || idx != 8) begin
      errors++; $display("FAIL bp_done got b=%b bits=%0d exp b=0 bits=8", busy, idx);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_o;
    @(negedge clk);
    load_data  = 8'hFF;
    load_valid = 1'b1;
    ser_ready  = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp_o = (k < 8);
      checks++;
      if (ser_valid !== 1'b1 || ser_out !== exp_o || sel !== 3'(k % 8) || load_ready !== (k % 8 == 7)) begin
        errors++; $display("FAIL b2b_cycle%0d got v=%b o=%b sel=%0d lr=%b exp v=1 o=%b sel=%0d lr=%b",
                           k, ser_valid, ser_out, sel, load_ready, exp_o, k % 8, (k % 8 == 7));
      end
      if (k == 0) load_data = 8'h00;
      if (k == 8) load_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (ser_valid !== 1'b0 || load_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_done got v=%b lr=%b exp v=0 lr=1", ser_valid, load_ready);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] w;
    w = 8'hF0;
    do_load(w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (sel !== 3'(i) || ser_out !== w[i]) begin
        errors++; $display("FAIL mr_pre%0d got sel=%0d o=%b exp sel=%0d o=%b", i, sel, ser_out, i, w[i]);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (load_ready !== 1'b0) begin errors++; $display("FAIL mr_load_ready got=%b exp=0", load_ready); end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (ser_valid !== 1'b0 || sel !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL mr_after got v=%b sel=%0d b=%b exp v=0 sel=0 b=0", ser_valid, sel, busy);
    end
    w = 8'h01;
    do_load(w);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (ser_valid !== 1'b1 || sel !== 3'(i) || ser_out !== w[i]) begin
        errors++; $display("FAIL mr_reload%0d got v=%b sel=%0d o=%b exp v=1 sel=%0d o=%b",
                           i, ser_valid, sel, ser_out, i, w[i]);
      end
    end
  endtask

  task automatic test_load_ignored();
    logic [7:0] w;
    w = 8'h5A;
    do_load(w);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      load_valid = 1'b0;
      checks++;
      if (ser_valid !== 1'b1 || sel !== 3'(i) || ser_out !== w[i]) begin
        errors++; $display("FAIL ign_bit%0d got v=%b sel=%0d o=%b exp v=1 sel=%0d o=%b",
                           i, ser_valid, sel, ser_out, i, w[i]);
      end
      if (i == 3) begin
        load_data  = 8'hFF;
        load_valid = 1'b1;
        #1;
        checks++;
        if (load_ready !== 1'b0) begin errors++; $display("FAIL ign_load_ready got=%b exp=0", load_ready); end
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ser_valid !== 1'b0) begin
      errors++; $display("FAIL ign_done got b=%b v=%b exp b=0 v=0", busy, ser_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_load_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
